// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer block.
//   DATA_W : default data width of the pass-through path
//   CNT_W  : default width of the saturating change counter
//   data_t : data word of the default width
package buffer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef logic [DATA_W-1:0] data_t;

endpackage : buffer_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear of the count
//   inc   : increment request, sampled on the rising edge
//   count : current count; sticks at all-ones once reached
module sat_counter #(
  parameter int unsigned W = buffer_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  import buffer_pkg::*;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Hold at all-ones so the debug count never wraps back to a small value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/buffer.sv
// Named pass-through boundary with a clocked debug side-band.
//   clk          : rising-edge clock for the side-band
//   rst_n        : asynchronous active-low clear of the side-band
//   I            : data in
//   O            : combinational copy of I (no clock, no reset dependence)
//   O_q          : I sampled at the last rising edge
//   changed      : last sample differed from the one before it
//   parity       : even parity (XOR-reduce) of the last sample
//   change_count : saturating count of sampled changes
module buffer #(
  parameter int unsigned WIDTH = buffer_pkg::DATA_W,
  parameter int unsigned CNT_W = buffer_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] O_q,
  output logic             changed,
  output logic             parity,
  output logic [CNT_W-1:0] change_count
);
  import buffer_pkg::*;

  // The data path itself: a plain wire, so glitches and X pass straight through.
  assign O = I;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             parity_q;
  logic             parity_d;
  logic             changed_q;
  logic             changed_d;
  logic             diff;

  // Compare against the previous sample; after reset that sample reads as zero,
  // so a nonzero first value counts as a change.
  always_comb begin
    diff      = (I != data_q);
    data_d    = I;
    parity_d  = ^I;
    changed_d = diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      parity_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      parity_q  <= parity_d;
      changed_q <= changed_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_change_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (diff),
    .count (change_count)
  );

  assign O_q     = data_q;
  assign parity  = parity_q;
  assign changed = changed_q;

endmodule : buffer

// File: tb/tb_buffer.sv
module tb_buffer;
  import buffer_pkg::*;

  logic        clk;
  logic        rst_n;
  data_t       I;
  data_t       O, O_q, O4, O_q4;
  logic        changed, parity, changed4, parity4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int n_assert;
  int n_fail;

  buffer u_dut (
    .clk(clk), .rst_n(rst_n), .I(I), .O(O), .O_q(O_q),
    .changed(changed), .parity(parity), .change_count(cnt16)
  );

  buffer #(.WIDTH(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .I(I), .O(O4), .O_q(O_q4),
    .changed(changed4), .parity(parity4), .change_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: remember the last two sampled words and how many sampled
  // transitions have happened; counters are that number clipped to their range.
  logic [15:0] m_last, m_prev;
  int          m_nchg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= '0;
      m_prev <= '0;
      m_nchg <= 0;
    end else begin
      m_prev <= m_last;
      m_last <= I;
      m_nchg <= m_nchg + ((I != m_last) ? 1 : 0);
    end
  end

  function automatic int clip(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_side(input string tag);
    chk({tag, "_O"},      32'(O),        32'(I));
    chk({tag, "_Oq"},     32'(O_q),      32'(m_last));
    chk({tag, "_par"},    32'(parity),   32'($countones(m_last) % 2));
    chk({tag, "_chg"},    32'(changed),  32'(m_last != m_prev));
    chk({tag, "_cnt16"},  32'(cnt16),    32'(clip(m_nchg, 65535)));
    chk({tag, "_cnt4"},   32'(cnt4),     32'(clip(m_nchg, 15)));
    chk({tag, "_Oq4"},    32'(O_q4),     32'(m_last));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check_side(tag);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset held with data present: O follows, side-band reads zero.
    rst_n = 1'b0;
    I     = 16'hA5A5;
    #1;
    chk("rst_O", 32'(O), 32'h0000_A5A5);
    chk("rst_Oq", 32'(O_q), 32'h0);
    chk("rst_par", 32'(parity), 32'h0);
    chk("rst_chg", 32'(changed), 32'h0);
    chk("rst_cnt", 32'(cnt16), 32'h0);
    tick("rst_hold");

    // Release and hold 0x0001 for three edges.
    rst_n = 1'b1;
    I     = 16'h0001;
    tick("rel1");
    chk("rel1_Oq", 32'(O_q), 32'h1);
    chk("rel1_par", 32'(parity), 32'h1);
    chk("rel1_chg", 32'(changed), 32'h1);
    chk("rel1_cnt", 32'(cnt16), 32'h1);
    tick("rel2");
    chk("rel2_chg", 32'(changed), 32'h0);
    tick("rel3");
    chk("rel3_chg", 32'(changed), 32'h0);
    chk("rel3_cnt", 32'(cnt16), 32'h1);

    // Random data every 2 time units; O must equal I with no delay.
    for (int k = 0; k < 25; k++) begin
      I = 16'($urandom);
      #1;
      chk("rand_O", 32'(O), 32'(I));
      #1;
    end
    tick("rand_edge");
    for (int k = 0; k < 8; k++) begin
      I = 16'($urandom);
      tick("rand_side");
    end

    // Fresh reset, five changes, then reset between edges.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      I = 16'(k);
      tick("cnt5");
    end
    chk("cnt5_val", 32'(cnt16), 32'h5);
    #3;
    rst_n = 1'b0;
    I     = 16'h1234;
    #1;
    chk("mid_O", 32'(O), 32'h1234);
    chk("mid_Oq", 32'(O_q), 32'h0);
    chk("mid_par", 32'(parity), 32'h0);
    chk("mid_chg", 32'(changed), 32'h0);
    chk("mid_cnt", 32'(cnt16), 32'h0);
    chk("mid_cnt4", 32'(cnt4), 32'h0);
    tick("mid_hold");

    // Alternate 0000/FFFF every edge: parity stays 0, 4-bit count saturates.
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      I = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
      tick("tog");
      chk("tog_chg", 32'(changed4), 32'h1);
      chk("tog_par", 32'(parity4), 32'h0);
    end
    chk("tog_sat4", 32'(cnt4), 32'hF);
    chk("tog_cnt16", 32'(cnt16), 32'd20);

    // Glitch 3 -> 7 -> 3 entirely between two edges.
    I = 16'h0003;
    tick("gl_a");
    tick("gl_b");
    #3;
    I = 16'h0007;
    #1;
    chk("gl_O7", 32'(O), 32'h7);
    I = 16'h0003;
    #1;
    chk("gl_O3", 32'(O), 32'h3);
    tick("gl_edge");
    chk("gl_chg", 32'(changed), 32'h0);
    chk("gl_cnt", 32'(cnt16), 32'd21);

    I = 16'h5A5A;
    #1;
    chk("end_O", 32'(O), 32'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_buffer
